demux_dispatch_1x4: RTL and testbench

- Registered 1-to-4 stream dispatcher with valid/ready handshaking on the input and on each of the four outputs.
- Each accepted word is routed to one of four output slots. The destination is either the word's 2-bit select (same encoding as the 1x4 demux: 0→y0 … 3→y3) or an internal round-robin pointer.
- Sits directly downstream of a single producer and feeds four independent consumers, replacing the combinational demux where back-pressure is needed.

---
 rtl/demux_dispatch_1x4.sv | 80 ++++++++
 tb/tb_demux_dispatch_1x4.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_dispatch_1x4.sv
// Registered 1-to-4 stream dispatcher: each accepted word lands in one output slot,
// chosen by in_sel or by an internal round-robin pointer, with per-slot valid/ready.
module demux_dispatch_1x4 #(
    parameter int WIDTH   = 8,
    parameter int RR_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [15:0]      accept_count
);

    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [3:0]       out_valid_q, out_valid_d;
    logic [WIDTH-1:0] slot_q [4];
    logic [WIDTH-1:0] slot_d [4];
    logic [15:0]      count_q, count_d;
    logic [1:0]       dest;
    logic             accept;

    always_comb begin
        dest = (RR_MODE != 0) ? rr_ptr_q : in_sel;
    end

    // A slot can take a new word when empty or when its current word leaves this same edge.
    assign in_ready = ~rst & (~out_valid_q[dest] | out_ready[dest]);
    assign accept   = in_valid & in_ready;

    always_comb begin
        out_valid_d = out_valid_q & ~out_ready;
        for (int k = 0; k < 4; k++) begin
            slot_d[k] = slot_q[k];
        end
        rr_ptr_d = rr_ptr_q;
        count_d  = count_q;
        if (accept) begin
            out_valid_d[dest] = 1'b1;
            slot_d[dest]      = in_data;
            rr_ptr_d          = rr_ptr_q + 2'd1;
            if (count_q != 16'hFFFF) begin
                count_d = count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 4'b0000;
            rr_ptr_q    <= 2'd0;
            count_q     <= 16'd0;
            for (int k = 0; k < 4; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
            count_q     <= count_d;
            for (int k = 0; k < 4; k++) begin
                slot_q[k] <= slot_d[k];
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data0    = slot_q[0];
    assign out_data1    = slot_q[1];
    assign out_data2    = slot_q[2];
    assign out_data3    = slot_q[3];
    assign accept_count = count_q;

endmodule

// File: tb/tb_demux_dispatch_1x4.sv
// Bench for demux_dispatch_1x4: runs a select-mode and a round-robin instance side by side
// against a queue-based reference model, plus directed literal scenarios.
module tb_demux_dispatch_1x4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic [1:0] in_sel;
    logic [3:0] out_ready;

    logic       ir [2];
    logic [3:0] ov [2];
    logic [7:0] od [2][4];
    logic [15:0] ac [2];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    demux_dispatch_1x4 #(.WIDTH(8), .RR_MODE(0)) dut_sel (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
        .in_data(in_data), .in_sel(in_sel), .out_valid(ov[0]), .out_ready(out_ready),
        .out_data0(od[0][0]), .out_data1(od[0][1]), .out_data2(od[0][2]), .out_data3(od[0][3]),
        .accept_count(ac[0])
    );

    demux_dispatch_1x4 #(.WIDTH(8), .RR_MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
        .in_data(in_data), .in_sel(in_sel), .out_valid(ov[1]), .out_ready(out_ready),
        .out_data0(od[1][0]), .out_data1(od[1][1]), .out_data2(od[1][2]), .out_data3(od[1][3]),
        .accept_count(ac[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per instance and slot, a queue of words waiting for their consumer.
    logic [7:0] sq [8][$];
    logic [7:0] mlast [8];
    logic [1:0] mptr [2];
    int         mcnt [2];

    always @(posedge clk) begin : model
        int  dst;
        bit  acc;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                sq[i].delete();
                mlast[i] = 8'h00;
            end
            for (int m = 0; m < 2; m++) begin
                mptr[m] = 2'd0;
                mcnt[m] = 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                dst = (m == 1) ? int'(mptr[m]) : int'(in_sel);
                acc = in_valid && (sq[m*4+dst].size() == 0 || out_ready[dst]);
                for (int k = 0; k < 4; k++) begin
                    if (sq[m*4+k].size() != 0 && out_ready[k]) void'(sq[m*4+k].pop_front());
                end
                if (acc) begin
                    sq[m*4+dst].push_back(in_data);
                    mlast[m*4+dst] = in_data;
                    mptr[m] = 2'((int'(mptr[m]) + 1) % 4);
                    if (mcnt[m] < 65535) mcnt[m] = mcnt[m] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        int         dst;
        logic       exp_rdy;
        logic [3:0] exp_v;
        logic [7:0] exp_d;
        if (chk_en) begin
            for (int m = 0; m < 2; m++) begin
                dst = (m == 1) ? int'(mptr[m]) : int'(in_sel);
                exp_rdy = !rst && (sq[m*4+dst].size() == 0 || out_ready[dst]);
                check($sformatf("m%0d_in_ready", m), ir[m], exp_rdy);
                for (int k = 0; k < 4; k++) exp_v[k] = (sq[m*4+k].size() != 0);
                check($sformatf("m%0d_out_valid", m), ov[m], exp_v);
                for (int k = 0; k < 4; k++) begin
                    exp_d = (sq[m*4+k].size() != 0) ? sq[m*4+k][0] : mlast[m*4+k];
                    check($sformatf("m%0d_data%0d", m, k), od[m][k], exp_d);
                end
                check($sformatf("m%0d_count", m), ac[m], mcnt[m]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [1:0] s,
                                 input logic [3:0] r);
        in_valid  = v;
        in_data   = d;
        in_sel    = s;
        out_ready = r;
    endtask

    logic [7:0] words [4];

    initial begin
        words = '{8'hA5, 8'h3C, 8'h7E, 8'h81};
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 2'd0, 4'b0000);
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        #1;

        // Reset then idle
        check("rst_valid", ov[0], 4'b0000);
        check("rst_count", ac[0], 16'd0);
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            check("rst_in_ready", ir[0], 1'b1);
        end

        // Direct routing
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, words[i], 2'(i), 4'b1111);
            tick();
            check("route_valid", ov[0], 4'b0001 << i);
            check("route_data", od[0][i], words[i]);
        end
        in_valid = 1'b0;
        check("route_count", ac[0], 16'd4);
        tick();

        // Back-pressure on slot 2
        applyStimulus(1'b1, 8'h11, 2'd2, 4'b1011);
        tick();
        check("bp_first", od[0][2], 8'h11);
        applyStimulus(1'b1, 8'h22, 2'd2, 4'b1011);
        #1;
        check("bp_stall_ready", ir[0], 1'b0);
        tick();
        check("bp_hold_data", od[0][2], 8'h11);
        check("bp_hold_valid", ov[0][2], 1'b1);
        out_ready = 4'b1111;
        #1;
        check("bp_release_ready", ir[0], 1'b1);
        tick();
        check("bp_swap_data", od[0][2], 8'h22);
        check("bp_swap_valid", ov[0][2], 1'b1);
        in_valid = 1'b0;
        tick();
        check("bp_drained", ov[0][2], 1'b0);

        // Parallel traffic past a blocked slot
        applyStimulus(1'b1, 8'h55, 2'd1, 4'b1101);
        tick();
        applyStimulus(1'b1, 8'h66, 2'd0, 4'b1101);
        #1;
        check("par_ready", ir[0], 1'b1);
        tick();
        check("par_data0", od[0][0], 8'h66);
        check("par_valid0", ov[0][0], 1'b1);
        check("par_data1", od[0][1], 8'h55);
        check("par_valid1", ov[0][1], 1'b1);
        applyStimulus(1'b0, 8'h00, 2'd0, 4'b1111);
        tick();

        // Round-robin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'(i + 1), 2'($urandom), 4'b1111);
            tick();
            check("rr_valid", ov[1], 4'b0001 << (i % 4));
            check("rr_data", od[1][i % 4], i + 1);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'(i + 6), 2'($urandom), 4'b1101);
            tick();
        end
        applyStimulus(1'b1, 8'h0A, 2'($urandom), 4'b1101);
        #1;
        check("rr_stall_ready", ir[1], 1'b0);
        tick();
        check("rr_stall_data", od[1][1], 8'h06);
        check("rr_stall_valid", ov[1][1], 1'b1);
        check("rr_still_stalled", ir[1], 1'b0);
        out_ready = 4'b1111;
        #1;
        check("rr_release_ready", ir[1], 1'b1);
        tick();
        check("rr_release_data", od[1][1], 8'h0A);
        check("rr_release_valid", ov[1][1], 1'b1);
        in_valid = 1'b0;
        tick();

        // Mid-operation reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, 8'h31, 2'd0, 4'b0000);
        tick();
        applyStimulus(1'b1, 8'h32, 2'd3, 4'b0000);
        tick();
        check("mid_pre_valid", ov[0], 4'b1001);
        rst = 1'b1;
        applyStimulus(1'b1, 8'h99, 2'd2, 4'b0000);
        #1;
        check("mid_rst_ready_sel", ir[0], 1'b0);
        check("mid_rst_ready_rr", ir[1], 1'b0);
        tick();
        check("mid_valid_sel", ov[0], 4'b0000);
        check("mid_valid_rr", ov[1], 4'b0000);
        check("mid_count_sel", ac[0], 16'd0);
        check("mid_count_rr", ac[1], 16'd0);
        rst = 1'b0;
        out_ready = 4'b1111;
        tick();
        check("mid_rr_ptr0", ov[1], 4'b0001);
        check("mid_rr_data", od[1][0], 8'h99);
        check("mid_sel_after", ov[0], 4'b0100);
        in_valid = 1'b0;
        tick();

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            applyStimulus($urandom_range(0, 9) < 7, 8'($urandom), 2'($urandom), 4'($urandom));
            tick();
        end
        rst = 1'b0;

        // Counter saturation
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, 8'h00, 2'd0, 4'b1111);
        for (int i = 0; i < 65540; i++) begin
            in_data = 8'(i);
            in_sel  = 2'(i);
            tick();
        end
        check("sat_count_sel", ac[0], 16'hFFFF);
        check("sat_count_rr", ac[1], 16'hFFFF);
        in_valid = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
